// File: rtl/aligner_pkg.sv
// Shared types and defaults for the mantissa aligner: FSM state encoding,
// default geometry and the width of the per-cycle shift-step counter.
package aligner_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEF   = 64;
  localparam int SHAMT_W_DEF = 11;
  localparam int STEP_DEF    = 8;

  // Bits needed to hold a step amount in 0..step inclusive.
  function automatic int step_cnt_w(input int step);
    return $clog2(step + 1);
  endfunction

  localparam int STEP_W = step_cnt_w(STEP_DEF);

endpackage

// File: rtl/mantissa_aligner_sticky_shift_step.sv
// One bounded right-shift step: shifts data by s (0..STEP) and reports the
// OR of the bits that fall off the LSB end.
module sticky_shift_step
  import aligner_pkg::*;
#(
  parameter int W    = WIDTH_DEF,
  parameter int STEP = STEP_DEF,
  parameter int SW   = STEP_W
) (
  input  logic [W-1:0]  data,
  input  logic [SW-1:0] s,
  output logic [W-1:0]  shifted,
  output logic          dropped
);

  always_comb begin
    shifted = data >> s;
    dropped = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (SW'(i) < s) dropped = dropped | data[i];
    end
  end

endmodule

// File: rtl/mantissa_aligner.sv
// Multi-cycle right-shift aligner with sticky collection, at most STEP bits per cycle.
// Optional macro ALIGNER_GUARD_EN adds out_guard/out_round via two extra LSBs.
module mantissa_aligner
  import aligner_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF,
  parameter int STEP    = STEP_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sticky
`ifdef ALIGNER_GUARD_EN
  ,
  output logic               out_guard,
  output logic               out_round
`endif
);

  localparam int SW = step_cnt_w(STEP);
`ifdef ALIGNER_GUARD_EN
  localparam int IW = WIDTH + 2;
`else
  localparam int IW = WIDTH;
`endif
  localparam logic [SHAMT_W-1:0] WIDTH_SH = SHAMT_W'(WIDTH);
  localparam logic [SHAMT_W-1:0] STEP_SH  = SHAMT_W'(STEP);

  state_t             state, state_next;
  logic [IW-1:0]      data, wide_in, sat_data, step_data;
  logic [SHAMT_W-1:0] rem, rem_next;
  logic [SW-1:0]      step_s;
  logic               sticky, sat_sticky, step_drop;
  logic               take, short_path;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign take       = in_valid & in_ready;
  assign short_path = (in_shamt == '0) || (in_shamt >= WIDTH_SH);

`ifdef ALIGNER_GUARD_EN
  assign wide_in = {in_data, 2'b00};
`else
  assign wide_in = in_data;
`endif

  // Saturating amounts resolve in one cycle; shifts past IW give zero data and a full-width mask.
  always_comb begin
    sat_data   = wide_in >> in_shamt;
    sat_sticky = |(wide_in & ~({IW{1'b1}} << in_shamt));
  end

  always_comb begin
    step_s   = (rem < STEP_SH) ? rem[SW-1:0] : SW'(STEP);
    rem_next = rem - SHAMT_W'(step_s);
  end

  sticky_shift_step #(
    .W    (IW),
    .STEP (STEP),
    .SW   (SW)
  ) u_step (
    .data    (data),
    .s       (step_s),
    .shifted (step_data),
    .dropped (step_drop)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take) state_next = short_path ? DONE : SHIFT;
      SHIFT:   if (rem_next == '0) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data   <= '0;
      rem    <= '0;
      sticky <= 1'b0;
    end else if (take) begin
      if (in_shamt >= WIDTH_SH) begin
        data   <= sat_data;
        sticky <= sat_sticky;
        rem    <= '0;
      end else begin
        data   <= wide_in;
        sticky <= 1'b0;
        rem    <= in_shamt;
      end
    end else if (state == SHIFT) begin
      data   <= step_data;
      sticky <= sticky | step_drop;
      rem    <= rem_next;
    end
  end

  assign out_data   = data[IW-1 -: WIDTH];
  assign out_sticky = sticky;
`ifdef ALIGNER_GUARD_EN
  assign out_guard  = data[1];
  assign out_round  = data[0];
`endif

endmodule

// File: tb/tb_mantissa_aligner.sv
// Self-checking bench for mantissa_aligner: directed boundary cases plus
// randomized operands against a bit-level reference model.
module tb_mantissa_aligner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [10:0] in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_sticky;
`ifdef ALIGNER_GUARD_EN
  logic        out_guard;
  logic        out_round;
`endif

  int errors = 0;
  int checks = 0;

  logic [63:0] obs_data;
  logic        obs_sticky, obs_guard, obs_round;
  int          obs_lat;

  mantissa_aligner dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_shamt   (in_shamt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky)
`ifdef ALIGNER_GUARD_EN
    ,
    .out_guard  (out_guard),
    .out_round  (out_round)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain arithmetic on the original operand bits.
  function automatic void model(input logic [63:0] d, input int sh,
                                output logic [63:0] od, output logic st,
                                output logic g, output logic r, output int lat);
    od = (sh >= 64) ? 64'd0 : d >> sh;
    st = 1'b0; g = 1'b0; r = 1'b0;
    for (int i = 0; i < 64; i++) begin
`ifdef ALIGNER_GUARD_EN
      if (i == sh - 1)     g = d[i];
      else if (i == sh - 2) r = d[i];
      else if (i < sh - 2)  st = st | d[i];
`else
      if (i < sh) st = st | d[i];
`endif
    end
    lat = (sh == 0 || sh >= 64) ? 1 : 1 + (sh + 7) / 8;
  endfunction

  task automatic issue(input logic [63:0] d, input logic [10:0] sh);
    @(negedge clk);
    in_data = d; in_shamt = sh; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_data = {$urandom, $urandom}; in_shamt = 11'($urandom);
    obs_lat = 1;
    while (!out_valid && obs_lat < 400) begin
      @(negedge clk);
      obs_lat++;
    end
    obs_data = out_data; obs_sticky = out_sticky;
`ifdef ALIGNER_GUARD_EN
    obs_guard = out_guard; obs_round = out_round;
`else
    obs_guard = 1'b0; obs_round = 1'b0;
`endif
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [63:0] d, input int sh);
    logic [63:0] ed; logic es, eg, er; int el;
    model(d, sh, ed, es, eg, er, el);
    issue(d, 11'(sh));
    checks++;
    if (obs_lat !== el) begin errors++; $display("FAIL %s latency: got %0d want %0d", name, obs_lat, el); end
    checks++;
    if (obs_data !== ed) begin errors++; $display("FAIL %s data: got %h want %h", name, obs_data, ed); end
    checks++;
    if (obs_sticky !== es) begin errors++; $display("FAIL %s sticky: got %b want %b", name, obs_sticky, es); end
`ifdef ALIGNER_GUARD_EN
    checks++;
    if ({obs_guard, obs_round} !== {eg, er}) begin
      errors++; $display("FAIL %s guard/round: got %b%b want %b%b", name, obs_guard, obs_round, eg, er);
    end
`endif
    release_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL %s release: valid=%b ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_shamt = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, out_sticky} !== 3'b100 || out_data !== 64'd0) begin
      errors++; $display("FAIL reset: ready=%b valid=%b sticky=%b data=%h want 1/0/0/0",
                         in_ready, out_valid, out_sticky, out_data);
    end
  endtask

  task automatic test_directed();
    check_op("zero_shift", 64'h8000_0000_0000_0001, 0);
    check_op("shift20",    64'h8000_0000_0000_0001, 20);
    check_op("sat64",      64'hFFFF_FFFF_FFFF_FFFF, 64);
    check_op("sat2047",    64'hFFFF_FFFF_FFFF_FFFF, 2047);
    check_op("zero_data",  64'h0, 100);
    check_op("shift63",    64'h8000_0000_0000_0000, 63);
    check_op("shift63b",   64'h7FFF_FFFF_FFFF_FFFF, 63);
    check_op("shift8",     64'h0000_0000_0000_01FF, 8);
    check_op("sat65",      64'hC000_0000_0000_0000, 65);
    check_op("shift1",     64'h0000_0000_0000_0003, 1);
`ifdef ALIGNER_GUARD_EN
    check_op("guard_b3",   64'h0000_0000_0000_000B, 3);
`endif
  endtask

  task automatic test_hold();
    logic [63:0] held;
    issue(64'h0000_0000_0000_00F0, 11'd4);
    checks++;
    if (obs_data !== 64'h0F || obs_sticky !== 1'b0) begin
      errors++; $display("FAIL hold result: data=%h sticky=%b want 0f/0", obs_data, obs_sticky);
    end
    held = obs_data;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = {$urandom, $urandom}; in_shamt = 11'd1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
        errors++; $display("FAIL hold cycle %0d: valid=%b data=%h ready=%b want 1/%h/0",
                           i, out_valid, out_data, in_ready, held);
      end
    end
    in_valid = 1'b0;
    release_result();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL hold no_accept: valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    @(negedge clk);
    in_data = 64'hFFFF_FFFF_FFFF_FFFF; in_shamt = 11'd40; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'd0 || out_sticky !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midreset: valid=%b data=%h sticky=%b ready=%b want 0/0/0/1",
                         out_valid, out_data, out_sticky, in_ready);
    end
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midreset stale: valid cycles=%0d want 0", seen); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [63:0] d;
      int sh;
      d = {$urandom, $urandom};
      if (n % 7 == 0) d = 64'd0;
      else if (n % 5 == 0) d = d >> $urandom_range(0, 63);
      case (n % 4)
        0: sh = $urandom_range(0, 2047);
        1: sh = $urandom_range(60, 70);
        default: sh = $urandom_range(0, 63);
      endcase
      check_op("random", d, sh);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
